// File: rtl/key_command_encoder.sv
// Front-panel command encoder: synchronises and debounces four push-buttons and
// issues one GPU command code per clean press, followed by a guaranteed zero gap.
module key_command_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter int unsigned GAP_CYCLES      = 4
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       btn_prev,
  input  logic       btn_next,
  input  logic       btn_rotate,
  input  logic       btn_negative,
  output logic [2:0] instruction,
  output logic       key_event
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  logic [3:0]           btn_raw;
  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           deb_q, deb_d, deb_dly_q;
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [CNT_WIDTH-1:0] cnt_d [4];
  logic [3:0]           rise;
  logic [1:0]           win_idx;

  state_t               state_q, state_d;
  logic [1:0]           held_idx_q, held_idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [2:0]           instruction_q, instruction_d;
  logic                 key_event_q, key_event_d;

  // Bit order doubles as priority order: lowest index wins.
  assign btn_raw = {btn_negative, btn_rotate, btn_next, btn_prev};
  assign rise    = deb_q & ~deb_dly_q;

  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) deb_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    if      (rise[0]) win_idx = 2'd0;
    else if (rise[1]) win_idx = 2'd1;
    else if (rise[2]) win_idx = 2'd2;
    else              win_idx = 2'd3;
  end

  always_comb begin
    state_d       = state_q;
    held_idx_d    = held_idx_q;
    gap_d         = gap_q;
    instruction_d = instruction_q;
    key_event_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|rise) begin
          held_idx_d    = win_idx;
          instruction_d = {1'b0, win_idx} + 3'd1;
          key_event_d   = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (!deb_q[held_idx_q]) begin
          instruction_d = '0;
          gap_d         = GAP_LOAD;
          state_d       = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      deb_q         <= '0;
      deb_dly_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q       <= IDLE;
      held_idx_q    <= '0;
      gap_q         <= '0;
      instruction_q <= '0;
      key_event_q   <= 1'b0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      deb_q         <= deb_d;
      deb_dly_q     <= deb_q;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q       <= state_d;
      held_idx_q    <= held_idx_d;
      gap_q         <= gap_d;
      instruction_q <= instruction_d;
      key_event_q   <= key_event_d;
    end
  end

  assign instruction = instruction_q;
  assign key_event   = key_event_q;

endmodule
